// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store unit between a CPU pipeline and a
// word-wide memory bus.
//
// A request is latched in IDLE. Aligned requests run one bus transaction (BUS) and
// finish with a one-cycle done pulse (RESP). Misaligned or invalid requests skip the
// bus and pulse exc_adel/exc_ades. A BUS phase lasting TIMEOUT_CYC cycles without
// bus_ack ends with exc_bus.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/we/size/    pipeline request (size 01=byte, 10=half, 11=word)
//   req_sext/addr/wdata
//   stall                 holds the pipeline while a request is being accepted or on the bus
//   done, rdata           completion pulse and extended load data (rdata held otherwise)
//   exc_adel/ades/bus     one-cycle exception pulses
//   bus_req/we/addr/be/   memory request, all zero outside BUS
//   bus_wdata
//   bus_ack, bus_rdata    memory completion and read word (same cycle)
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StResp = 2'd2
    } state_e;

    // What RESP reports; exactly one pulse output is decoded from it.
    typedef enum logic [1:0] {
        RespDone = 2'd0,
        RespAdel = 2'd1,
        RespAdes = 2'd2,
        RespBus  = 2'd3
    } resp_e;

    localparam logic [1:0] SizeByte = 2'b01;
    localparam logic [1:0] SizeHalf = 2'b10;
    localparam logic [1:0] SizeWord = 2'b11;

    localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYC);

    state_e      state_q, state_d;
    resp_e       resp_q, resp_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned;
    logic [7:0]  cnt_inc;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [3:0]  be_dec;
    logic [31:0] wdata_rep;
    logic        in_bus;
    logic        in_resp;

    // Alignment check on the incoming (not yet latched) request.
    always_comb begin
        misaligned = (req_size == 2'b00)
                  || (req_size == SizeHalf && req_addr[0])
                  || (req_size == SizeWord && req_addr[1:0] != 2'b00);
    end

    // Load lane extraction and extension from the latched request.
    always_comb begin
        byte_lane = bus_rdata[7:0];
        unique case (addr_q[1:0])
            2'd0: byte_lane = bus_rdata[7:0];
            2'd1: byte_lane = bus_rdata[15:8];
            2'd2: byte_lane = bus_rdata[23:16];
            2'd3: byte_lane = bus_rdata[31:24];
            default: byte_lane = bus_rdata[7:0];
        endcase
        half_lane = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        load_data = bus_rdata;
        if (size_q == SizeByte) begin
            load_data = {{24{sext_q & byte_lane[7]}}, byte_lane};
        end else if (size_q == SizeHalf) begin
            load_data = {{16{sext_q & half_lane[15]}}, half_lane};
        end
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be_dec    = 4'b0000;
        wdata_rep = wdata_q;
        unique case (size_q)
            SizeByte: begin
                be_dec    = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            SizeHalf: begin
                be_dec    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            SizeWord: begin
                be_dec    = 4'b1111;
                wdata_rep = wdata_q;
            end
            default: begin
                be_dec    = 4'b0000;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        cnt_inc = cnt_q + 8'd1;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sext_d  = req_sext;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (misaligned) begin
                        state_d = StResp;
                        resp_d  = req_we ? RespAdes : RespAdel;
                    end else begin
                        state_d = StBus;
                        cnt_d   = 8'd0;
                    end
                end
            end
            StBus: begin
                // Ack wins over a timeout in the same cycle.
                if (bus_ack) begin
                    state_d = StResp;
                    resp_d  = RespDone;
                    rdata_d = we_q ? 32'd0 : load_data;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutLim) begin
                        state_d = StResp;
                        resp_d  = RespBus;
                    end
                end
            end
            StResp: begin
                // req_valid is deliberately ignored here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            resp_q  <= RespDone;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs. stall is gated by rst_n so a held req_valid cannot stall during reset.
    always_comb begin
        in_bus    = (state_q == StBus);
        in_resp   = (state_q == StResp);

        stall     = rst_n && (((state_q == StIdle) && req_valid) || in_bus);

        bus_req   = in_bus;
        bus_we    = in_bus & we_q;
        bus_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
        bus_be    = in_bus ? be_dec : 4'b0000;
        bus_wdata = in_bus ? wdata_rep : 32'd0;

        done      = in_resp && (resp_q == RespDone);
        exc_adel  = in_resp && (resp_q == RespAdel);
        exc_ades  = in_resp && (resp_q == RespAdes);
        exc_bus   = in_resp && (resp_q == RespBus);

        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven bench for mem_access_ctrl (TIMEOUT_CYC = 4).
// Expected completions are queued when a request is driven and compared when the DUT
// pulses done/exc_*; multi-cycle corner cases are hand-written sequences.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 4;

    localparam logic [1:0] KDone = 2'd0;
    localparam logic [1:0] KAdel = 2'd1;
    localparam logic [1:0] KAdes = 2'd2;
    localparam logic [1:0] KBus  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_bus   (exc_bus),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] rdata;
        logic        chk_rdata;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;   // BUS cycle index carrying bus_ack; -1 = never
        logic [31:0] brdata;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [1:0]  kind;
        logic [31:0] rdata;
    } vec_t;

    exp_t  sb[$];
    vec_t  vecs[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string tag = "init";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%08h, want 0x%08h", tag, name, act, exp);
        end
    endtask

    function automatic logic [31:0] kind_of(input logic [3:0] p);
        case (p)
            4'b0001: kind_of = 32'd0;
            4'b0010: kind_of = 32'd1;
            4'b0100: kind_of = 32'd2;
            4'b1000: kind_of = 32'd3;
            default: kind_of = 32'd15;
        endcase
    endfunction

    task automatic push_exp(input logic [1:0] kind, input logic [31:0] rd);
        exp_t e;
        e.kind      = kind;
        e.rdata     = rd;
        e.chk_rdata = (kind == KDone);
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every response pulse must match the oldest expectation.
    logic [3:0] pulses;
    exp_t       got_e;
    always @(negedge clk) begin
        pulses = {exc_bus, exc_ades, exc_adel, done};
        if (rst_n === 1'b1 && pulses != 4'b0000) begin
            check("pulse_onehot", 32'($countones(pulses)), 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {28'd0, pulses}, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check("resp_kind", kind_of(pulses), {30'd0, got_e.kind});
                if (got_e.chk_rdata) check("rdata", rdata, got_e.rdata);
            end
        end
    end

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic run_vec(input vec_t v);
        bit fin;
        fin = 1'b0;
        @(negedge clk);
        check("idle_bus_quiet",
              {26'd0, bus_req, bus_we, bus_be} | bus_addr | bus_wdata, 32'd0);
        drive_req(v.we, v.size, v.sext, v.addr, v.wdata);
        #1;
        check("stall_idle", 32'(stall), 32'd1);
        push_exp(v.kind, v.rdata);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (v.kind == KAdel || v.kind == KAdes) begin
            @(negedge clk);
            check("exc_latency", 32'(exc_adel | exc_ades), 32'd1);
            check("exc_no_bus", 32'(bus_req), 32'd0);
            check("exc_no_stall", 32'(stall), 32'd0);
        end else begin
            for (int i = 0; i < 8 && !fin; i++) begin
                @(negedge clk);
                check("bus_req", 32'(bus_req), 32'd1);
                check("bus_we", 32'(bus_we), 32'(v.we));
                check("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
                check("bus_be", 32'(bus_be), 32'(v.be));
                check("bus_wdata", bus_wdata, v.bwd);
                check("stall_bus", 32'(stall), 32'd1);
                if (i == v.ack_dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = v.brdata;
                end else begin
                    bus_rdata = $urandom;
                end
                @(posedge clk);
                #1 bus_ack = 1'b0;
                bus_rdata  = $urandom;
                if (i == v.ack_dly || i == int'(TO) - 1) fin = 1'b1;
            end
            @(negedge clk);
            check("resp_latency", 32'(done | exc_bus), 32'd1);
            check("resp_bus_idle", 32'(bus_req), 32'd0);
            check("resp_no_stall", 32'(stall), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        drive_req(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'd0);

        // Reset state, with req_valid already high.
        tag = "reset";
        #12;
        check("stall", 32'(stall), 32'd0);
        check("bus_quiet", {26'd0, bus_req, bus_we, bus_be} | bus_addr | bus_wdata, 32'd0);
        check("pulses", {28'd0, exc_bus, exc_ades, exc_adel, done}, 32'd0);
        check("rdata", rdata, 32'd0);

        // First request accepted on the first rising edge after release.
        tag = "first_req";
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(KDone, 32'hFFFF_FF80);
        #1;
        check("stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bus_req", 32'(bus_req), 32'd1);
        check("bus_be", 32'(bus_be), 32'b0100);
        req_valid = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h0080_0000;
        @(posedge clk);
        #1 bus_ack = 1'b0;
        @(negedge clk);
        check("done", 32'(done), 32'd1);

        // Table: we size sext addr wdata ack_dly bus_rdata | be bus_wdata kind rdata
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h1003, 32'h0000_00A5, 1, 32'h0,
                         4'b1000, 32'hA5A5_A5A5, KDone, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h2002, 32'h0, 0, 32'h8001_1234,
                         4'b1100, 32'h0, KDone, 32'hFFFF_8001});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h2002, 32'h0, 1, 32'h8001_1234,
                         4'b1100, 32'h0, KDone, 32'h0000_8001});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h3001, 32'h0, 0, 32'h0,
                         4'b0000, 32'h0, KAdel, 32'h0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h3001, 32'h1234, 0, 32'h0,
                         4'b0000, 32'h0, KAdes, 32'h0});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h4000, 32'hDEAD_BEEF, 0, 32'h0,
                         4'b1111, 32'hDEAD_BEEF, KDone, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h5001, 32'h0, 0, 32'h1122_8033,
                         4'b0010, 32'h0, KDone, 32'hFFFF_FF80});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h5002, 32'h0, 2, 32'h11AA_2233,
                         4'b0100, 32'h0, KDone, 32'h0000_00AA});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h6000, 32'h0, 0, 32'h7FFF_7ABC,
                         4'b0011, 32'h0, KDone, 32'h0000_7ABC});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h8000, 32'h0, -1, 32'h0,
                         4'b0001, 32'h0, KBus, 32'h0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h8004, 32'h0, 3, 32'h0BAD_CAFE,
                         4'b1111, 32'h0, KDone, 32'h0BAD_CAFE});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h9000, 32'h0, 0, 32'h0,
                         4'b0000, 32'h0, KAdel, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h9000, 32'h0, 0, 32'h0,
                         4'b0000, 32'h0, KAdes, 32'h0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h9002, 32'h0000_BEEF, 0, 32'h0,
                         4'b1100, 32'hBEEF_BEEF, KDone, 32'h0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h9000, 32'hFFFF_FF5A, 1, 32'h0,
                         4'b0001, 32'h5A5A_5A5A, KDone, 32'h0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h7000, 32'h0, 2, 32'hCAFE_F00D,
                         4'b1111, 32'h0, KDone, 32'hCAFE_F00D});

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("vec%0d", i);
            run_vec(vecs[i]);
        end

        // bus_ack outside BUS is ignored and rdata holds its last value.
        tag = "stray_ack";
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        repeat (2) @(negedge clk);
        check("bus_req", 32'(bus_req), 32'd0);
        check("rdata_hold", rdata, 32'hCAFE_F00D);
        bus_ack = 1'b0;

        // Reset in the middle of BUS: abandoned with no pulse, outputs drop at once.
        tag = "reset_mid_bus";
        @(negedge clk);
        drive_req(1'b0, 2'b11, 1'b0, 32'h0000_B000, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bus_req_pre", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("bus_req_async", 32'(bus_req), 32'd0);
        check("stall_async", 32'(stall), 32'd0);
        check("rdata_async", rdata, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("bus_req_after", 32'(bus_req), 32'd0);
        tag = "after_reset";
        run_vec('{1'b0, 2'b11, 1'b0, 32'h0000_C000, 32'h0, 1, 32'h2468_ACE0,
                  4'b1111, 32'h0, KDone, 32'h2468_ACE0});

        // Back-to-back byte loads with req_valid held high.
        tag = "b2b";
        @(negedge clk);
        drive_req(1'b0, 2'b01, 1'b0, 32'h0000_A000, 32'd0);
        push_exp(KDone, 32'h0000_00C3);
        @(posedge clk);
        @(negedge clk);
        check("bus_req1", 32'(bus_req), 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_00C3;
        @(posedge clk);
        #1 bus_ack = 1'b0;
        @(negedge clk);
        check("done1", 32'(done), 32'd1);
        check("resp_stall", 32'(stall), 32'd0);
        check("resp_bus", 32'(bus_req), 32'd0);
        req_addr = 32'h0000_A001;
        push_exp(KDone, 32'h0000_00C3);
        @(negedge clk);
        check("idle_bus", 32'(bus_req), 32'd0);
        check("idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check("bus_req2", 32'(bus_req), 32'd1);
        check("bus_be2", 32'(bus_be), 32'b0010);
        req_valid = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_C300;
        @(posedge clk);
        #1 bus_ack = 1'b0;
        @(negedge clk);
        check("done2", 32'(done), 32'd1);

        repeat (2) @(negedge clk);
        tag = "end";
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYC, default 255, the number of BUS-state cycles without bus_ack before a bus error is raised (range 1..255).
REQ-002 The block SHALL have these ports:
- clk  in  1  the only clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  pipeline memory request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  01 = byte, 10 = half, 11 = word, 00 = invalid.
- req_sext  in  1  1 = sign-extend load data, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  holds the pipeline.
- done  out  1  one-cycle pulse; access completed.
- rdata  out  32  extended load data, valid while done=1.
- exc_adel  out  1  one-cycle pulse; misaligned or invalid load.
- exc_ades  out  1  one-cycle pulse; misaligned or invalid store.
- exc_bus  out  1  one-cycle pulse; bus timeout.
- bus_req  out  1  memory request.
- bus_we  out  1  memory write.
- bus_addr  out  32  {addr[31:2], 2'b00}.
- bus_be  out  4  byte-lane enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  memory completion; bus_rdata is valid in the same cycle.
- bus_rdata  in  32  memory read word.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUS and RESP.
REQ-004 In IDLE with req_valid=1, the block SHALL latch all req_* inputs.
- Aligned request: go to BUS.
- Misaligned or invalid request: go to RESP with the exception flag set.
REQ-005 Misaligned or invalid SHALL mean any of:
- req_size=00;
- req_size=10 with addr[0]=1;
- req_size=11 with addr[1:0]≠00.
REQ-006 bus_be SHALL be decoded from the latched size and addr[1:0]:
- byte: 4'b0001 << addr[1:0];
- half: 4'b0011 if addr[1]=0, else 4'b1100;
- word: 4'b1111.
REQ-007 bus_wdata SHALL be:
- byte: {4{wdata[7:0]}};
- half: {2{wdata[15:0]}};
- word: wdata.
REQ-008 bus_req SHALL be 1 exactly while in BUS, with bus_we/addr/be/wdata held stable; all bus_* outputs SHALL be 0 outside BUS.
REQ-009 In BUS, bus_ack=1 SHALL move the FSM to RESP with done scheduled.
- Loads capture the extracted lane of bus_rdata.
- Byte loads use lane addr[1:0]; half loads use lane addr[1].
- The captured lane is sign- or zero-extended per req_sext.
- Word loads pass bus_rdata unchanged.
- Stores capture rdata = 0.
REQ-010 A cycle counter SHALL clear on BUS entry and increment each BUS cycle without ack. When it reaches TIMEOUT_CYC, the FSM SHALL go to RESP with exc_bus set. bus_ack in the same cycle as the timeout SHALL take priority, giving a normal completion.
REQ-011 In RESP, exactly one of done/exc_adel/exc_ades/exc_bus SHALL be 1 for one cycle, req_valid SHALL be ignored, and the next state SHALL be IDLE.
REQ-012 stall SHALL be combinational: (state==IDLE && req_valid) || state==BUS; it SHALL be 0 in RESP.
REQ-013 Latency SHALL be as follows, for a request accepted at edge T and bus_ack sampled k cycles after bus_req rises:
- done SHALL be high in cycle T+k+1.
- A misaligned request SHALL pulse its exception in cycle T+1 with no bus activity.
REQ-014 bus_ack outside BUS SHALL be ignored.
REQ-015 rdata SHALL hold its last value outside done cycles.

Reset
REQ-016 rst_n=0 SHALL immediately force, asynchronously:
- FSM to IDLE;
- counter to 0;
- all outputs to 0, including bus_req and stall (since req_valid is gated by IDLE/reset);
- rdata to 0.
REQ-017 Reset asserted mid-BUS SHALL abandon the transaction without a done or exception pulse.
REQ-018 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Byte store, addr=0x1003, wdata=0x000000A5, ack after 2 cycles -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000, done once, rdata=0.
- Half load with sext, addr=0x2002, bus_rdata=0x8001_1234 -> bus_be=1100, rdata=0xFFFF8001. The same with sext=0 -> rdata=0x00008001.
- Word load, addr=0x3001 -> exc_adel in the next cycle, bus_req never asserted. Half store at 0x3001 -> exc_ades.
- TIMEOUT_CYC=4, no ack -> exc_bus after 4 BUS cycles, bus_req drops. A repeat run with ack on the 4th cycle -> done, no exc_bus.
- rst_n low during BUS -> bus_req and stall fall without a clock edge, no done pulse. A new request after release completes normally.
- Back-to-back byte loads with req_valid held high -> the RESP cycle ignores req_valid, and the second access starts exactly one cycle after the first done.
